// File: rtl/gf2_poly_divider.sv
`default_nettype none
// ============================================================================
// Module      : gf2_poly_divider
// Description : Iterative GF(2) long divider, one dividend bit per clock.
//               A = Q*B ^ R, deg R < deg B. Define EARLY_TERM_EN to stop the
//               division once the step at the divisor degree is done.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_poly_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);

    localparam int CW = $clog2(2 * N);
    localparam int DW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [2*N-1:0] q_q;
    logic [N-1:0]   r_q;
    logic           dz_q;
    logic [2*N-1:0] w_q;
    logic [2*N-1:0] qw_q;
    logic [N-1:0]   bq_q;
    logic [DW-1:0]  d_q;
    logic [CW-1:0]  cnt_q;

    logic [DW-1:0]  msb_d;
    logic [CW-1:0]  d_ext_d;
    logic [CW-1:0]  shamt_d;
    logic           take_d;
    logic           last_d;
    logic [2*N-1:0] w_d;
    logic [2*N-1:0] qw_d;

    // Divisor degree: the last set bit seen while scanning upward wins.
    always_comb begin
        msb_d = '0;
        for (int k = 0; k < N; k++) begin
            if (b[k]) begin
                msb_d = k[DW-1:0];
            end
        end
    end

    assign d_ext_d = CW'(d_q);
    assign shamt_d = cnt_q - d_ext_d;
    assign take_d  = (cnt_q >= d_ext_d) && w_q[cnt_q];
    assign w_d     = take_d ? (w_q ^ ({{N{1'b0}}, bq_q} << shamt_d)) : w_q;
    assign qw_d    = take_d ? (qw_q | ({{(2*N-1){1'b0}}, 1'b1} << shamt_d)) : qw_q;

`ifdef EARLY_TERM_EN
    // Steps below the divisor degree can never cancel a bit, so stop here.
    assign last_d  = (cnt_q == d_ext_d);
`else
    assign last_d  = (cnt_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            w_q         <= '0;
            qw_q        <= '0;
            bq_q        <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_q        <= a;
                        bq_q       <= b;
                        d_q        <= msb_d;
                        qw_q       <= '0;
                        cnt_q      <= CW'(2 * N - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (bq_q == '0) begin
                        q_q         <= '0;
                        r_q         <= '0;
                        dz_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        w_q  <= w_d;
                        qw_q <= qw_d;
                        if (last_d) begin
                            q_q         <= qw_d;
                            r_q         <= w_d[N-1:0];
                            dz_q        <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;

endmodule
`default_nettype wire
